// File: rtl/periph_bus_pkg.sv
// ---------------------------------------------------------------------------
// periph_bus_pkg
//   Shared definitions for the peripheral bus arbiter slice:
//   - FSM state encoding (IDLE / ACCESS / RESP)
//   - master indices (M0 = MIPS core, M1 = DMA/debug)
//   - bus widths and the default access timeout
//   - a small helper that returns the opposite master index
// ---------------------------------------------------------------------------
package periph_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int DEFAULT_TIMEOUT = 16;

    // Index of the master that was not the given one.
    function automatic logic other_master(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/periph_bus_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Combinational two-way picker.
//   Ports:
//     req[1:0]  in   live request levels, bit 0 = M0, bit 1 = M1
//     last_gnt  in   master granted by the previous completed transaction
//     rr_en     in   1 = alternate on a tie, 0 = M0 always wins a tie
//     gnt_idx   out  index of the selected master (meaningful when valid=1)
//     valid     out  at least one master is requesting
// ---------------------------------------------------------------------------
module rr_arb2
    import periph_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       rr_en,
    output logic       gnt_idx,
    output logic       valid
);

    // Select the winner from the request pattern and the priority mode.
    always_comb begin
        gnt_idx = M0;
        valid   = 1'b0;
        case (req)
            2'b01: begin
                gnt_idx = M0;
                valid   = 1'b1;
            end
            2'b10: begin
                gnt_idx = M1;
                valid   = 1'b1;
            end
            2'b11: begin
                valid = 1'b1;
                if (rr_en) begin
                    gnt_idx = other_master(last_gnt);
                end else begin
                    gnt_idx = M0;
                end
            end
            default: begin
                gnt_idx = M0;
                valid   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// ---------------------------------------------------------------------------
// periph_bus_arbiter
//   Shares the peripheral bus between M0 (MIPS core) and M1 (DMA/debug).
//   One transaction at a time: the winner's rw/addr/wdata are latched in
//   IDLE, driven on the bus during ACCESS until bus_ack or timeout, and the
//   result is returned to the winner as a one-cycle done pulse in RESP.
//
//   Parameters:
//     TIMEOUT      max ACCESS cycles without bus_ack before err (>= 2)
//     ROUND_ROBIN  1 = alternate priority on ties, 0 = M0 always wins
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     m0_req/rw/addr/wdata        M0 request side
//     m0_rdata/done/err           M0 response (rdata/err qualified by done)
//     m1_*                        same for M1
//     bus_ce/rw/addr/wdata        peripheral bus command (all registered)
//     bus_rdata, bus_ack          peripheral response, sampled in ACCESS only
//     busy                        high in ACCESS and RESP
// ---------------------------------------------------------------------------
module periph_bus_arbiter
    import periph_bus_pkg::*;
#(
    parameter int TIMEOUT     = DEFAULT_TIMEOUT,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_rw,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_done,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_rw,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_done,
    output logic              m1_err,

    output logic              bus_ce,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,

    output logic              busy
);

    // One extra bit so TIMEOUT-1 is always representable; ACCESS exits at
    // TIMEOUT-1, so the counter never wraps.
    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_r;
    logic              last_gnt_r;
    logic              gnt_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              pick_idx_s;
    logic              pick_valid_s;
    logic              sel_rw_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              finish_s;
    logic              resp_err_s;
    logic [DATA_W-1:0] resp_rdata_s;

    rr_arb2 u_rr_arb2 (
        .req      ({m1_req, m0_req}),
        .last_gnt (last_gnt_r),
        .rr_en    (ROUND_ROBIN),
        .gnt_idx  (pick_idx_s),
        .valid    (pick_valid_s)
    );

    // Route the winning master's command fields toward the bus latches.
    always_comb begin
        sel_rw_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        if (pick_idx_s == M1) begin
            sel_rw_s    = m1_rw;
            sel_addr_s  = m1_addr;
            sel_wdata_s = m1_wdata;
        end else begin
            sel_rw_s    = m0_rw;
            sel_addr_s  = m0_addr;
            sel_wdata_s = m0_wdata;
        end
    end

    // ACCESS end condition and response payload; ack has priority over the
    // timeout, and writes or timeouts return zero data.
    always_comb begin
        finish_s     = bus_ack || (cnt_r == CNT_LAST);
        resp_err_s   = 1'b0;
        resp_rdata_s = '0;
        if (bus_ack) begin
            resp_err_s = 1'b0;
            if (bus_rw) begin
                resp_rdata_s = '0;
            end else begin
                resp_rdata_s = bus_rdata;
            end
        end else begin
            resp_err_s   = 1'b1;
            resp_rdata_s = '0;
        end
    end

    // Transaction FSM with latched command, timeout counter and registered
    // response outputs; done/err/rdata default to 0 every cycle so they
    // pulse for exactly the RESP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            last_gnt_r <= M1;
            gnt_r      <= M0;
            cnt_r      <= '0;
            bus_ce     <= 1'b0;
            bus_rw     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            busy       <= 1'b0;
            m0_done    <= 1'b0;
            m0_err     <= 1'b0;
            m0_rdata   <= '0;
            m1_done    <= 1'b0;
            m1_err     <= 1'b0;
            m1_rdata   <= '0;
        end else begin
            m0_done  <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= '0;
            m1_done  <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        gnt_r     <= pick_idx_s;
                        bus_rw    <= sel_rw_s;
                        bus_addr  <= sel_addr_s;
                        bus_wdata <= sel_wdata_s;
                        bus_ce    <= 1'b1;
                        busy      <= 1'b1;
                        cnt_r     <= '0;
                        state_r   <= ST_ACCESS;
                    end else begin
                        bus_ce  <= 1'b0;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (finish_s) begin
                        bus_ce  <= 1'b0;
                        state_r <= ST_RESP;
                        if (gnt_r == M1) begin
                            m1_done  <= 1'b1;
                            m1_err   <= resp_err_s;
                            m1_rdata <= resp_rdata_s;
                        end else begin
                            m0_done  <= 1'b1;
                            m0_err   <= resp_err_s;
                            m0_rdata <= resp_rdata_s;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_RESP: begin
                    last_gnt_r <= gnt_r;
                    cnt_r      <= '0;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    bus_ce  <= 1'b0;
                    busy    <= 1'b0;
                    cnt_r   <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_periph_bus_arbiter
//   Two arbiters share one stimulus: one with ROUND_ROBIN=1, one with
//   ROUND_ROBIN=0. A table of single transactions is applied in order, then
//   a hand-written mid-ACCESS reset sequence follows.
// ---------------------------------------------------------------------------
module tb_periph_bus_arbiter;
    import periph_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_rw, m1_req, m1_rw;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_bus_addr, rr_bus_wdata;
    logic        rr_m0_done, rr_m0_err, rr_m1_done, rr_m1_err;
    logic        rr_bus_ce, rr_bus_rw, rr_busy;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_bus_addr, fp_bus_wdata;
    logic        fp_m0_done, fp_m0_err, fp_m1_done, fp_m1_err;
    logic        fp_bus_ce, fp_bus_rw, fp_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    periph_bus_arbiter #(.TIMEOUT(16), .ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(rr_m0_rdata), .m0_done(rr_m0_done), .m0_err(rr_m0_err),
        .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(rr_m1_rdata), .m1_done(rr_m1_done), .m1_err(rr_m1_err),
        .bus_ce(rr_bus_ce), .bus_rw(rr_bus_rw), .bus_addr(rr_bus_addr),
        .bus_wdata(rr_bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .busy(rr_busy)
    );

    periph_bus_arbiter #(.TIMEOUT(16), .ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(fp_m0_rdata), .m0_done(fp_m0_done), .m0_err(fp_m0_err),
        .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(fp_m1_rdata), .m1_done(fp_m1_done), .m1_err(fp_m1_err),
        .bus_ce(fp_bus_ce), .bus_rw(fp_bus_rw), .bus_addr(fp_bus_addr),
        .bus_wdata(fp_bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .busy(fp_busy)
    );

    typedef struct {
        logic        m0_req, m1_req, m0_rw, m1_rw;
        logic [31:0] a0, a1, w0, w1;
        int          ack_at;      // ACCESS cycle index (0-based) carrying ack
        logic [31:0] rd;          // bus_rdata presented during the access
        logic        g_rr, g_fp;  // expected winner per instance
        int          exp_ce;      // expected number of bus_ce cycles
        logic        exp_err;
        logic [31:0] rd_rr, rd_fp;
    } vec_t;

    vec_t tbl[9];

    function automatic vec_t mkv(input logic r0, input logic r1, input logic rw0,
                                 input logic rw1, input logic [31:0] a0,
                                 input logic [31:0] a1, input logic [31:0] w0,
                                 input logic [31:0] w1, input int ack_at,
                                 input logic [31:0] rd, input logic g_rr,
                                 input logic g_fp, input int exp_ce,
                                 input logic exp_err, input logic [31:0] rd_rr,
                                 input logic [31:0] rd_fp);
        vec_t v;
        v.m0_req = r0;  v.m1_req = r1;  v.m0_rw = rw0; v.m1_rw = rw1;
        v.a0 = a0;      v.a1 = a1;      v.w0 = w0;     v.w1 = w1;
        v.ack_at = ack_at; v.rd = rd;   v.g_rr = g_rr; v.g_fp = g_fp;
        v.exp_ce = exp_ce; v.exp_err = exp_err;
        v.rd_rr = rd_rr;   v.rd_fp = rd_fp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response of one instance in its RESP cycle.
    task automatic chk_resp(input string tag, input logic gnt, input logic err,
                            input logic [31:0] rd, input logic d0, input logic e0,
                            input logic [31:0] r0, input logic d1, input logic e1,
                            input logic [31:0] r1);
        chk({tag, " m0_done"},  {31'd0, d0}, {31'd0, gnt == M0});
        chk({tag, " m1_done"},  {31'd0, d1}, {31'd0, gnt == M1});
        chk({tag, " m0_err"},   {31'd0, e0}, {31'd0, (gnt == M0) && err});
        chk({tag, " m1_err"},   {31'd0, e1}, {31'd0, (gnt == M1) && err});
        chk({tag, " m0_rdata"}, r0, (gnt == M0) ? rd : 32'h0000_0000);
        chk({tag, " m1_rdata"}, r1, (gnt == M1) ? rd : 32'h0000_0000);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " rr_done"}, {30'd0, rr_m1_done, rr_m0_done}, 32'h0);
        chk({tag, " fp_done"}, {30'd0, fp_m1_done, fp_m0_done}, 32'h0);
        chk({tag, " rr_busy"}, {31'd0, rr_busy}, 32'h0);
        chk({tag, " fp_busy"}, {31'd0, fp_busy}, 32'h0);
        chk({tag, " rr_ce"},   {31'd0, rr_bus_ce}, 32'h0);
        chk({tag, " fp_ce"},   {31'd0, fp_bus_ce}, 32'h0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int ce_cnt;
        logic [31:0] ea_rr, ew_rr, ea_fp, ew_fp;
        logic erw_rr, erw_fp;
        ea_rr  = (v.g_rr == M1) ? v.a1 : v.a0;
        ew_rr  = (v.g_rr == M1) ? v.w1 : v.w0;
        erw_rr = (v.g_rr == M1) ? v.m1_rw : v.m0_rw;
        ea_fp  = (v.g_fp == M1) ? v.a1 : v.a0;
        ew_fp  = (v.g_fp == M1) ? v.w1 : v.w0;
        erw_fp = (v.g_fp == M1) ? v.m1_rw : v.m0_rw;
        // An ack while idle must be ignored.
        @(negedge clk);
        m0_req = 1'b0; m1_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk_quiet({tag, " idle_ack"});
        bus_ack = 1'b0;
        m0_req = v.m0_req; m1_req = v.m1_req; m0_rw = v.m0_rw; m1_rw = v.m1_rw;
        m0_addr = v.a0; m1_addr = v.a1; m0_wdata = v.w0; m1_wdata = v.w1;
        bus_rdata = v.rd;
        ce_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!rr_bus_ce) break;
            ce_cnt++;
            chk({tag, " rr_addr"},  rr_bus_addr, ea_rr);
            chk({tag, " rr_wdata"}, rr_bus_wdata, ew_rr);
            chk({tag, " rr_rw"},    {31'd0, rr_bus_rw}, {31'd0, erw_rr});
            chk({tag, " fp_ce"},    {31'd0, fp_bus_ce}, 32'h1);
            chk({tag, " fp_addr"},  fp_bus_addr, ea_fp);
            chk({tag, " fp_rw"},    {31'd0, fp_bus_rw}, {31'd0, erw_fp});
            chk({tag, " busy"},     {31'd0, rr_busy}, 32'h1);
            chk({tag, " early_done"}, {30'd0, rr_m1_done, rr_m0_done}, 32'h0);
            if (c == 0) begin
                // Mid-transaction input changes must not reach the bus.
                m0_addr = ~v.a0; m1_addr = ~v.a1; m0_wdata = ~v.w0; m1_wdata = ~v.w1;
                m0_rw = ~v.m0_rw; m1_rw = ~v.m1_rw;
            end
            bus_ack = (c == v.ack_at);
        end
        bus_ack = 1'b0;
        chk({tag, " ce_cycles"}, ce_cnt, v.exp_ce);
        chk({tag, " resp_busy"}, {31'd0, rr_busy}, 32'h1);
        chk_resp({tag, " rr"}, v.g_rr, v.exp_err, v.rd_rr, rr_m0_done, rr_m0_err,
                 rr_m0_rdata, rr_m1_done, rr_m1_err, rr_m1_rdata);
        chk_resp({tag, " fp"}, v.g_fp, v.exp_err, v.rd_fp, fp_m0_done, fp_m0_err,
                 fp_m0_rdata, fp_m1_done, fp_m1_err, fp_m1_rdata);
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        chk_quiet({tag, " after"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        r0    r1    rw0   rw1   a0            a1            w0            w1            ack rd            grr fp  ce err rd_rr         rd_fp
        tbl[0] = mkv(1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0100, 32'h0, 32'hDEAD_BEEF, 32'h0, 0, 32'hCAFE_0001, M0, M0, 1, 1'b0, 32'h0, 32'h0);
        tbl[1] = mkv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h4000_0020, 32'h0, 32'h0, 3, 32'h0000_00A5, M1, M1, 4, 1'b0, 32'h0000_00A5, 32'h0000_00A5);
        tbl[2] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 32'h1000_0000, 32'h2000_0000, 32'h0, 32'h0, 1, 32'h1111_1111, M0, M0, 2, 1'b0, 32'h1111_1111, 32'h1111_1111);
        tbl[3] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 32'h1000_0004, 32'h2000_0004, 32'h0, 32'h0, 0, 32'h2222_2222, M1, M0, 1, 1'b0, 32'h2222_2222, 32'h2222_2222);
        tbl[4] = mkv(1'b1, 1'b1, 1'b1, 1'b1, 32'h1000_0008, 32'h2000_0008, 32'hA0A0_A0A0, 32'hB0B0_B0B0, 2, 32'h3333_3333, M0, M0, 3, 1'b0, 32'h0, 32'h0);
        tbl[5] = mkv(1'b1, 1'b1, 1'b1, 1'b1, 32'h1000_000C, 32'h2000_000C, 32'hA1A1_A1A1, 32'hB1B1_B1B1, 0, 32'h4444_4444, M1, M0, 1, 1'b0, 32'h0, 32'h0);
        tbl[6] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h3000_0000, 32'h0, 32'h0, 32'h0, 99, 32'h5555_5555, M0, M0, 16, 1'b1, 32'h0, 32'h0);
        tbl[7] = mkv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h3000_0010, 32'h0, 32'h0, 15, 32'h1234_5678, M1, M1, 16, 1'b0, 32'h1234_5678, 32'h1234_5678);
        tbl[8] = mkv(1'b1, 1'b0, 1'b1, 1'b0, 32'h3000_0020, 32'h0, 32'h0BAD_F00D, 32'h0, 2, 32'h6666_6666, M0, M0, 3, 1'b0, 32'h0, 32'h0);

        rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0; m0_rw = 1'b0; m1_rw = 1'b0;
        m0_addr = 32'h0; m1_addr = 32'h0; m0_wdata = 32'h0; m1_wdata = 32'h0;
        bus_rdata = 32'h0; bus_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        chk("reset rr_addr",  rr_bus_addr, 32'h0);
        chk("reset rr_wdata", rr_bus_wdata, 32'h0);
        chk("reset rr_rdata", rr_m0_rdata | rr_m1_rdata, 32'h0);
        chk("reset rr_err",   {30'd0, rr_m1_err, rr_m0_err}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset during the second ACCESS cycle; RR last grant is M0 here, so
        // the interrupted tie goes to M1, and after reset the tie goes to M0.
        @(negedge clk);
        m0_req = 1'b1; m1_req = 1'b1; m0_rw = 1'b0; m1_rw = 1'b0;
        m0_addr = 32'h7000_0000; m1_addr = 32'h7100_0000; bus_ack = 1'b0;
        @(negedge clk);
        chk("rst_seq rr_ce",   {31'd0, rr_bus_ce}, 32'h1);
        chk("rst_seq rr_addr", rr_bus_addr, 32'h7100_0000);
        @(negedge clk);
        chk("rst_seq rr_ce2",  {31'd0, rr_bus_ce}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("rst_seq post");
        chk("rst_seq rr_err", {30'd0, rr_m1_err, rr_m0_err}, 32'h0);
        rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        chk_quiet("rst_seq idle");
        run_vec(mkv(1'b1, 1'b1, 1'b0, 1'b0, 32'h7200_0000, 32'h7300_0000, 32'h0, 32'h0,
                    0, 32'h0000_0077, M0, M0, 1, 1'b0, 32'h0000_0077, 32'h0000_0077),
                "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
